// File: rtl/asteroid_pkg.sv
// Shared constants for the asteroid descent controller: state encoding, field widths, LFSR taps.
package asteroid_pkg;

    localparam int COL_W = 4;
    localparam int ROW_W = 4;
    localparam logic [7:0] SCORE_MAX = 8'd255;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_SPAWN = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAP_MASK), s[15:1]};
    endfunction

endpackage

// File: rtl/asteroid_lfsr.sv
// 16-bit spawn LFSR; free-running, reloaded with SEED on reset or i_load.
module asteroid_lfsr
    import asteroid_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
)(
    input  logic       cin,
    input  logic       resetn,
    input  logic       i_load,
    output logic [4:0] o_rand
);

    logic [15:0] r_lfsr;

    always_ff @(posedge cin or negedge resetn) begin
        if (!resetn) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_rand = r_lfsr[4:0];

endmodule

// File: rtl/asteroid_descent_ctrl.sv
// Asteroid descent controller: per tick, steps every slot down one row, scores hits/dodges, spawns.
// Build option ASTEROID_FORCE_SPAWN_EN: SPAWN fills a free slot regardless of lfsr[0].
module asteroid_descent_ctrl
    import asteroid_pkg::*;
#(
    parameter int          NUM_AST   = 4,
    parameter int          ROWS      = 12,
    parameter int          LIVES     = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
)(
    input  logic                     cin,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     tick,
    input  logic [COL_W-1:0]         player_col,
    output logic [NUM_AST-1:0]       ast_valid,
    output logic [COL_W*NUM_AST-1:0] ast_col,
    output logic [ROW_W*NUM_AST-1:0] ast_row,
    output logic [1:0]               lives,
    output logic [7:0]               score,
    output logic                     busy,
    output logic                     game_over
);

    localparam int IDX_W = (NUM_AST > 1) ? $clog2(NUM_AST) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [2:0]               r_state;
    logic [2:0]               w_state_nxt;
    logic [IDX_W-1:0]         r_idx;
    logic [NUM_AST-1:0]       r_valid;
    logic [COL_W*NUM_AST-1:0] r_col;
    logic [ROW_W*NUM_AST-1:0] r_row;
    logic [1:0]               r_lives;
    logic [7:0]               r_score;
    logic                     r_busy;
    logic                     r_game_over;

    logic [4:0]       w_lfsr;
    logic             w_lfsr_load;
    logic             w_clear;
    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_spawn;
    logic             w_cur_valid;
    logic [ROW_W-1:0] w_cur_row;
    logic [COL_W-1:0] w_cur_col;

    assign w_lfsr_load = (r_state == ST_IDLE) && start;

    asteroid_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .cin    (cin),
        .resetn (resetn),
        .i_load (w_lfsr_load),
        .o_rand (w_lfsr)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if (!start) w_state_nxt = ST_IDLE;
                      else if (tick) w_state_nxt = ST_STEP;
            ST_STEP:  if (!start) w_state_nxt = ST_IDLE;
                      else if (r_idx == IDX_W'(NUM_AST - 1)) w_state_nxt = ST_SPAWN;
            ST_SPAWN: if (!start) w_state_nxt = ST_IDLE;
                      else if (r_lives == 2'd0) w_state_nxt = ST_OVER;
                      else w_state_nxt = ST_RUN;
            ST_OVER:  if (!start) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Slots are wiped on any entry to IDLE and again when a new game starts.
    assign w_clear = ((r_state != ST_IDLE) && (w_state_nxt == ST_IDLE)) || w_lfsr_load;

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_AST - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

`ifdef ASTEROID_FORCE_SPAWN_EN
    assign w_spawn = w_free_found;
`else
    assign w_spawn = w_free_found & w_lfsr[0];
`endif

    assign w_cur_valid = r_valid[r_idx];
    assign w_cur_row   = r_row[r_idx*ROW_W +: ROW_W];
    assign w_cur_col   = r_col[r_idx*COL_W +: COL_W];

    always_ff @(posedge cin or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_valid     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_lives     <= 2'(LIVES);
            r_score     <= 8'd0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt == ST_STEP) || (w_state_nxt == ST_SPAWN);
            r_game_over <= (w_state_nxt == ST_OVER);
            r_idx       <= (r_state == ST_STEP) ? r_idx + IDX_W'(1) : '0;

            if (w_clear) begin
                r_valid <= '0;
                r_col   <= '0;
                r_row   <= '0;
            end else if (r_state == ST_STEP && w_cur_valid) begin
                if (w_cur_row != ROW_LAST) begin
                    r_row[r_idx*ROW_W +: ROW_W] <= w_cur_row + 1'b1;
                end else begin
                    r_valid[r_idx]              <= 1'b0;
                    r_row[r_idx*ROW_W +: ROW_W] <= '0;
                    r_col[r_idx*COL_W +: COL_W] <= '0;
                    if (w_cur_col == player_col) begin
                        if (r_lives != 2'd0) r_lives <= r_lives - 2'd1;
                    end else if (r_score != SCORE_MAX) begin
                        r_score <= r_score + 8'd1;
                    end
                end
            end else if (r_state == ST_SPAWN && w_spawn) begin
                r_valid[w_free_idx]                <= 1'b1;
                r_row[w_free_idx*ROW_W +: ROW_W]   <= '0;
                r_col[w_free_idx*COL_W +: COL_W]   <= w_lfsr[4:1];
            end

            if (w_lfsr_load) begin
                r_lives <= 2'(LIVES);
                r_score <= 8'd0;
            end
        end
    end

    assign ast_valid = r_valid;
    assign ast_col   = r_col;
    assign ast_row   = r_row;
    assign lives     = r_lives;
    assign score     = r_score;
    assign busy      = r_busy;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_asteroid_descent_ctrl.sv
// Directed bench for asteroid_descent_ctrl with a per-tick reference model of slots, lives and score.
module tb_asteroid_descent_ctrl;

    localparam int NUM_AST = 4;
    localparam int ROWS    = 12;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                 cin = 1'b0;
    logic                 resetn;
    logic                 start;
    logic                 tick;
    logic [3:0]           player_col;
    logic [NUM_AST-1:0]   ast_valid;
    logic [4*NUM_AST-1:0] ast_col;
    logic [4*NUM_AST-1:0] ast_row;
    logic [1:0]           lives;
    logic [7:0]           score;
    logic                 busy;
    logic                 game_over;

    asteroid_descent_ctrl #(
        .NUM_AST(NUM_AST), .ROWS(ROWS), .LIVES(3), .LFSR_SEED(SEED)
    ) dut (
        .cin        (cin),
        .resetn     (resetn),
        .start      (start),
        .tick       (tick),
        .player_col (player_col),
        .ast_valid  (ast_valid),
        .ast_col    (ast_col),
        .ast_row    (ast_row),
        .lives      (lives),
        .score      (score),
        .busy       (busy),
        .game_over  (game_over)
    );

    always #10 cin = ~cin;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_lfsr = SEED;
    bit          load_pend = 1'b0;
    int m_valid[NUM_AST];
    int m_row[NUM_AST];
    int m_col[NUM_AST];
    int m_lives, m_score, m_over;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    // One clock edge, then sample point 1 time unit later; tracks the expected LFSR value.
    task automatic clk1();
        @(posedge cin);
        if (!resetn || load_pend) m_lfsr = SEED;
        else m_lfsr = ref_lfsr_step(m_lfsr);
        load_pend = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_AST; i++) begin
            m_valid[i] = 0; m_row[i] = 0; m_col[i] = 0;
        end
        m_lives = 3; m_score = 0; m_over = 0;
    endtask

    task automatic model_tick(input logic [15:0] lf);
        bit spawn_ok;
        bit placed;
        for (int i = 0; i < NUM_AST; i++) begin
            if (m_valid[i] != 0) begin
                if (m_row[i] < ROWS - 1) m_row[i]++;
                else begin
                    if (m_col[i] == int'(player_col)) begin
                        if (m_lives > 0) m_lives--;
                    end else if (m_score < 255) m_score++;
                    m_valid[i] = 0;
                end
            end
        end
`ifdef ASTEROID_FORCE_SPAWN_EN
        spawn_ok = 1'b1;
`else
        spawn_ok = lf[0];
`endif
        placed = 1'b0;
        for (int i = 0; i < NUM_AST; i++) begin
            if (spawn_ok && !placed && m_valid[i] == 0) begin
                m_valid[i] = 1; m_row[i] = 0; m_col[i] = int'(lf[4:1]);
                placed = 1'b1;
            end
        end
        if (m_lives == 0) m_over = 1;
    endtask

    function automatic logic [3:0] pick_dodge();
        bit bad;
        for (int c = 0; c < 16; c++) begin
            bad = 1'b0;
            for (int i = 0; i < NUM_AST; i++)
                if (m_valid[i] != 0 && m_row[i] == ROWS - 1 && m_col[i] == c) bad = 1'b1;
            if (!bad) return 4'(c);
        end
        return 4'd0;
    endfunction

    function automatic logic [3:0] pick_hit();
        for (int i = 0; i < NUM_AST; i++)
            if (m_valid[i] != 0 && m_row[i] == ROWS - 1) return 4'(m_col[i]);
        return 4'd0;
    endfunction

    task automatic compare_all(input string tag);
        for (int i = 0; i < NUM_AST; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), 32'(ast_valid[i]), m_valid[i]);
            if (m_valid[i] != 0) begin
                chk($sformatf("%s_row%0d", tag, i), 32'(ast_row[i*4 +: 4]), m_row[i]);
                chk($sformatf("%s_col%0d", tag, i), 32'(ast_col[i*4 +: 4]), m_col[i]);
            end
        end
        chk({tag, "_lives"}, 32'(lives), m_lives);
        chk({tag, "_score"}, 32'(score), m_score);
        chk({tag, "_over"}, 32'(game_over), m_over);
    endtask

    // Tick in cycle t; STEP t+1..t+NUM_AST, SPAWN t+NUM_AST+1, results checked at t+NUM_AST+2.
    task automatic run_tick(input bit dbl);
        logic [15:0] lf;
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        chk("busy_step", 32'(busy), 1);
        for (int k = 1; k < NUM_AST; k++) begin
            clk1();
            tick = (dbl && k == 1);
            chk("busy_step", 32'(busy), 1);
        end
        clk1();
        tick = 1'b0;
        lf = m_lfsr;
        chk("busy_spawn", 32'(busy), 1);
        clk1();
        model_tick(lf);
        chk("busy_done", 32'(busy), 0);
        compare_all("tick");
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; tick = 1'b0; player_col = 4'd0;
        model_reset();
        clk1(); clk1();
        chk("rst_valid", 32'(ast_valid), 0);
        chk("rst_col", 32'(ast_col), 0);
        chk("rst_row", 32'(ast_row), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_score", 32'(score), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_over", 32'(game_over), 0);

        resetn = 1'b1;
        tick = 1'b1; clk1(); tick = 1'b0; clk1();
        chk("idle_tick_busy", 32'(busy), 0);
        chk("idle_tick_valid", 32'(ast_valid), 0);

        // Tick coincident with start rising must be ignored.
        start = 1'b1; tick = 1'b1; load_pend = 1'b1;
        clk1();
        tick = 1'b0;
        clk1();
        chk("start_tick_busy", 32'(busy), 0);
        chk("start_tick_valid", 32'(ast_valid), 0);
        model_reset();

        for (int n = 0; n < 16; n++) begin
            player_col = pick_dodge();
            run_tick(n == 0 || n == 5);
        end

        for (int n = 0; n < 60 && m_over == 0; n++) begin
            player_col = pick_hit();
            run_tick(1'b0);
        end

        if (m_over != 0) begin
            tick = 1'b1; clk1(); tick = 1'b0; clk1();
            chk("over_tick_busy", 32'(busy), 0);
            compare_all("over_freeze");
        end
        start = 1'b0;
        clk1(); clk1();
        chk("idle_over_clr", 32'(game_over), 0);
        chk("idle_busy", 32'(busy), 0);

        // start dropped in the first STEP cycle abandons the step.
        start = 1'b1; load_pend = 1'b1;
        clk1();
        model_reset();
        for (int n = 0; n < 3; n++) begin
            player_col = pick_dodge();
            run_tick(1'b0);
        end
        tick = 1'b1; clk1(); tick = 1'b0;
        start = 1'b0;
        clk1();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(ast_valid), 0);
        chk("abort_score", 32'(score), m_score);
        chk("abort_lives", 32'(lives), m_lives);
        clk1();

        // Asynchronous reset in the middle of a STEP, then a replay from the seed.
        start = 1'b1; load_pend = 1'b1;
        clk1();
        model_reset();
        for (int n = 0; n < 2; n++) begin
            player_col = pick_dodge();
            run_tick(1'b0);
        end
        tick = 1'b1; clk1(); tick = 1'b0; clk1();
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(ast_valid), 0);
        chk("arst_row", 32'(ast_row), 0);
        chk("arst_col", 32'(ast_col), 0);
        chk("arst_lives", 32'(lives), 3);
        chk("arst_score", 32'(score), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_over", 32'(game_over), 0);
        clk1();
        resetn = 1'b1; load_pend = 1'b1;
        clk1();
        model_reset();
        for (int n = 0; n < 5; n++) begin
            player_col = pick_dodge();
            run_tick(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/asteroid_descent_ctrl.md
Name: asteroid_descent_ctrl

Overview:
- Consumes the one-cycle descent tick from the game clock divider.
- On each tick, moves every live asteroid down one row and resolves asteroids reaching the bottom row as either a player hit or a dodge.
- Spawns new asteroids from an internal LFSR.
- Drives asteroid positions, lives, score and game_over to the renderer and HUD.

Parameters:
- NUM_AST, 4, number of asteroid slots (2..8).
- ROWS, 12, playfield rows; row ROWS-1 is the player row.
- LIVES, 3, lives loaded at game start (1..3).
- LFSR_SEED, 16'hACE1, reset and start value of the spawn LFSR (must be nonzero).

Ports:
- cin  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- start  in  1  game-run level; same signal that enables the descent divider
- tick  in  1  one-cycle descent pulse from the divider
- player_col  in  4  current player column, 0..15
- ast_valid  out  NUM_AST  slot occupied
- ast_col  out  4*NUM_AST  column of slot i at [4i+3:4i]
- ast_row  out  4*NUM_AST  row of slot i at [4i+3:4i]
- lives  out  2  remaining lives
- score  out  8  dodged-asteroid count, saturating at 255
- busy  out  1  high in STEP and SPAWN
- game_over  out  1  high in OVER

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; ast_valid=0; ast_col=0; ast_row=0.
  - lives=LIVES; score=0; busy=0; game_over=0; lfsr=LFSR_SEED.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle except in reset.
- IDLE:
  - On start=1: clear all slots, lives=LIVES, score=0, lfsr=LFSR_SEED, go to RUN.
- RUN:
  - tick=1 -> STEP with slot index i=0.
  - start=0 -> IDLE; slots cleared; score and lives hold.
- STEP: one slot per cycle, i = 0..NUM_AST-1.
  - Valid slot with row < ROWS-1: row increments by 1.
  - Valid slot with row == ROWS-1 and col == player_col: lives decrements (saturates at 0); slot cleared.
  - Valid slot with row == ROWS-1 and col != player_col: score increments (saturates at 255); slot cleared.
  - After i = NUM_AST-1 -> SPAWN.
- SPAWN (1 cycle):
  - Spawn condition: lfsr[0]=1 and at least one free slot.
  - If met, the lowest-index free slot is set to valid=1, row=0, col=lfsr[4:1].
  - A slot cleared during this STEP counts as free.
  - Next state: OVER if lives==0, else RUN.
- OVER:
  - game_over=1; slots freeze.
  - start=0 -> IDLE (game_over clears).
- Latency:
  - tick at cycle t -> STEP occupies t+1..t+NUM_AST; SPAWN at t+NUM_AST+1.
  - All outputs are stable from t+NUM_AST+2.
- Boundary conditions:
  - tick while busy=1, or in IDLE/OVER, is dropped (not queued).
  - start=0 while busy -> IDLE on the next cycle; the step is abandoned.
  - Multiple hits in one step each decrement lives, saturating at 0; OVER is entered once.
  - A tick coincident with start rising is ignored (IDLE->RUN takes priority).
  - Reset mid-operation returns immediately to the reset values.
- Outputs are registered; there are no combinational paths from input to output.

Optional Feature:
- Macro: ASTEROID_FORCE_SPAWN_EN.
- Defined: SPAWN ignores lfsr[0] and always fills a free slot if one exists. Column still comes from lfsr[4:1]. Intended for deterministic demo and bench runs.
- Undefined: spawning is gated by lfsr[0] as above.

Decomposition:
- Package asteroid_pkg holds:
  - state encoding (IDLE=0, RUN=1, STEP=2, SPAWN=3, OVER=4)
  - COL_W=4, ROW_W=4, SCORE_MAX=8'd255
  - LFSR tap constants.
- One sub-module, asteroid_lfsr: 16-bit LFSR with seed load and async active-low reset.

Test Plan:
- Reset with start=0 -> ast_valid=0, lives=3, score=0, game_over=0, busy=0; tick pulses cause no state change.
- ASTEROID_FORCE_SPAWN_EN, start=1, one tick -> busy high for 5 cycles; slot 0 valid at row 0, col=lfsr[4:1]; outputs stable at t+6.
- Drive 12 further ticks with player_col != the asteroid's col -> asteroid reaches row 11, then clears on the next tick; score=1.
- Same sequence with player_col == the asteroid's col -> lives=2; the third such hit -> lives=0, game_over=1; start=0 -> IDLE, game_over=0.
- Tick pulsed again 2 cycles after a first tick (while busy) -> rows advance exactly once.
- Deassert resetn mid-STEP -> all outputs return to their reset values asynchronously; start=1 afterwards replays a deterministic spawn sequence from LFSR_SEED.
